// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed 7-segment scan with anti-ghost blanking and frame-synchronous value load
module h27seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);
  localparam logic [6:0] LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  assign seg = LUT[hex];
endmodule

module seg7_scan_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 12000,
  parameter int BLANK    = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [4*NDIGITS-1:0]   value_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic                   lz_blank,
  input  logic                   load_valid,
  output logic                   load_ready,
  output logic [6:0]             seg,
  output logic                   dp,
  output logic [NDIGITS-1:0]     an,
  output logic                   frame_done
);
  localparam int CW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int IW = NDIGITS > 1 ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BL = CW'(BLANK);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIGITS - 1);
  typedef enum logic {S_BLANK, S_SHOW} state_t;
  state_t state;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx;
  logic [4*NDIGITS-1:0] disp, pend;
  logic [NDIGITS-1:0] disp_dp, pend_dp;
  logic pend_full, cnt_last, frame_end, sup, show;
  logic [3:0] dig;
  logic [6:0] dec_seg;
  assign cnt_last = cnt == LAST;
  assign cnt_nxt = cnt_last ? '0 : cnt + 1'b1;
  assign frame_end = cnt_last && idx == IDX_LAST;
  assign load_ready = ~pend_full;
  assign dig = disp[{idx, 2'b00} +: 4];
  h27seg u_dec (.hex(dig), .seg(dec_seg));
  // A digit is suppressed when it and every more-significant nibble are zero
  always_comb begin
    sup = lz_blank && idx != '0;
    for (int j = 0; j < NDIGITS; j++)
      if (j >= int'(idx) && disp[4*j +: 4] != 4'h0) sup = 1'b0;
    show = state == S_SHOW && !sup;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= BLANK > 0 ? S_BLANK : S_SHOW;
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      disp_dp    <= '0;
      pend       <= '0;
      pend_dp    <= '0;
      pend_full  <= 1'b0;
      an         <= '1;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      state      <= (BLANK > 0 && cnt_nxt < BL) ? S_BLANK : S_SHOW;
      if (cnt_last) idx <= idx == IDX_LAST ? '0 : idx + 1'b1;
      an         <= show ? ~(NDIGITS'(1) << idx) : '1;
      seg        <= show ? dec_seg : 7'h7F;
      dp         <= show ? ~disp_dp[idx] : 1'b1;
      frame_done <= frame_end;
      // ready is low while a commit is pending, so commit and capture never collide
      if (frame_end && pend_full) begin
        disp      <= pend;
        disp_dp   <= pend_dp;
        pend_full <= 1'b0;
      end else if (load_valid && !pend_full) begin
        pend      <= value_in;
        pend_dp   <= dp_in;
        pend_full <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized scan/load scenarios against a frame-timing reference model
module tb_seg7_scan_ctrl;
  localparam int N = 4, P = 8, B = 2;
  logic clk = 0, resetn = 0;
  logic [15:0] value_in = '0;
  logic [3:0] dp_in = '0;
  logic lz_blank = 0, load_valid = 0;
  logic load_ready, dp, frame_done;
  logic [6:0] seg;
  logic [3:0] an;
  int checks = 0, errors = 0;
  int t;
  logic [15:0] m_disp, m_pend;
  logic [3:0] m_dpb, m_pdp;
  logic m_pf, m_took;
  logic [3:0] e_an;
  logic [6:0] e_seg;
  logic e_dp, e_fd, e_rdy;
  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_ctrl #(.NDIGITS(N), .PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .resetn(resetn), .value_in(value_in), .dp_in(dp_in), .lz_blank(lz_blank),
    .load_valid(load_valid), .load_ready(load_ready), .seg(seg), .dp(dp), .an(an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_dpb = '0; m_pdp = '0; m_pf = 0; m_took = 0;
  endtask

  // Expected pins after the next edge follow from absolute time t and the committed value
  task automatic tick();
    int slot, c;
    logic lit;
    logic [3:0] nib;
    slot = (t / P) % N;
    c = t % P;
    nib = 4'(m_disp >> (4 * slot));
    lit = c >= B && !(lz_blank && slot != 0 && (m_disp >> (4 * slot)) == 0);
    e_an = lit ? ~(4'b1 << slot) : 4'hF;
    e_seg = lit ? segtab[nib] : 7'h7F;
    e_dp = lit ? ~m_dpb[slot] : 1'b1;
    e_fd = slot == N - 1 && c == P - 1;
    m_took = 0;
    if (e_fd && m_pf) begin
      m_disp = m_pend; m_dpb = m_pdp; m_pf = 0;
    end else if (load_valid && !m_pf) begin
      m_pend = value_in; m_pdp = dp_in; m_pf = 1; m_took = 1;
    end
    e_rdy = !m_pf;
    @(posedge clk); #1;
    t++;
  endtask

  task automatic test_reset();
    resetn = 0;
    repeat (4) begin
      @(posedge clk); #1;
      value_in = 16'($urandom); dp_in = 4'($urandom); lz_blank = 1'($urandom); load_valid = 1'($urandom);
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL reset_hold got=%b exp=%b", {an, seg, dp, frame_done, load_ready}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
      end
    end
    value_in = '0; dp_in = '0; lz_blank = 0; load_valid = 0;
    resetn = 1;
    model_reset();
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL reset_release t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
      if (k == 2) begin
        checks++;
        if ({an, seg} !== {4'b1110, 7'b1000000}) begin
          errors++;
          $display("FAIL first_digit0 got an=%b seg=%b exp an=1110 seg=1000000", an, seg);
        end
      end
    end
  endtask

  task automatic test_load_1234();
    value_in = 16'h1234; dp_in = '0; lz_blank = 0; load_valid = 1;
    tick();
    load_valid = 0;
    checks++;
    if (load_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_1234_ready got=%b exp=0", load_ready);
    end
    repeat (2 * N * P) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL load_1234 t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
    end
  endtask

  task automatic test_lz();
    logic [15:0] vals [2] = '{16'h0050, 16'h0000};
    lz_blank = 1; dp_in = '0;
    for (int v = 0; v < 2; v++) begin
      value_in = vals[v]; load_valid = 1;
      for (int w = 0; w < 200 && !m_took; w++) tick();
      load_valid = 0;
      repeat (2 * N * P) begin
        tick();
        checks++;
        if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
          errors++;
          $display("FAIL lz_%04h t=%0d got=%b exp=%b", vals[v], t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
        end
      end
    end
    lz_blank = 0;
  endtask

  task automatic test_back_to_back();
    int w;
    value_in = 16'hA5A5; dp_in = 4'b0001; load_valid = 1;
    for (w = 0; w < 200 && !m_took; w++) tick();
    value_in = 16'h3C7E; dp_in = 4'b1000;
    m_took = 0;
    for (w = 0; w < 200 && !m_took; w++) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL b2b_hold t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
    end
    load_valid = 0;
    checks++;
    if (w >= 200) begin
      errors++;
      $display("FAIL b2b_timeout got=no_capture exp=capture");
    end
    repeat (3 * N * P) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL b2b_show t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
    end
  endtask

  task automatic test_dp();
    value_in = 16'h8888; dp_in = 4'b0100; lz_blank = 0; load_valid = 1;
    for (int w = 0; w < 200 && !m_took; w++) tick();
    load_valid = 0;
    repeat (2 * N * P) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL dp t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 40; it++) begin
      if (!load_valid) begin
        value_in = 16'($urandom); dp_in = 4'($urandom);
        if ($urandom_range(3) == 0) value_in = value_in & 16'h00FF;
        load_valid = $urandom_range(2) == 0;
      end
      lz_blank = 1'($urandom);
      repeat ($urandom_range(20, 1)) begin
        tick();
        if (m_took) load_valid = 0;
        checks++;
        if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
          errors++;
          $display("FAIL random t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
        end
      end
    end
    load_valid = 0; lz_blank = 0;
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 200 && m_pf; w++) tick();
    value_in = 16'hABCD; dp_in = 4'b1111; load_valid = 1;
    tick();
    load_valid = 0;
    for (int w = 0; w < 200 && m_pf; w++) tick();
    value_in = 16'h5678; load_valid = 1;
    tick();
    load_valid = 0;
    for (int w = 0; w < 200 && !((t / P) % N == 2 && t % P == 3); w++) tick();
    checks++;
    if (load_ready !== 1'b0 || an !== 4'b1011) begin
      errors++;
      $display("FAIL mid_pre got rdy=%b an=%b exp rdy=0 an=1011", load_ready, an);
    end
    #2 resetn = 0;
    #1;
    checks++;
    if ({an, seg, dp, frame_done, load_ready} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_async got=%b exp=%b", {an, seg, dp, frame_done, load_ready}, {4'hF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    resetn = 1;
    model_reset();
    repeat (2 * N * P) begin
      tick();
      checks++;
      if ({an, seg, dp, frame_done, load_ready} !== {e_an, e_seg, e_dp, e_fd, e_rdy}) begin
        errors++;
        $display("FAIL mid_after t=%0d got=%b exp=%b", t, {an, seg, dp, frame_done, load_ready}, {e_an, e_seg, e_dp, e_fd, e_rdy});
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_1234();
    test_lz();
    test_back_to_back();
    test_dp();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one segment bus. It owns a single instance of the `h27seg` hex decoder and sequences it across `NDIGITS` digits with a per-slot anti-ghosting blank interval. New display values are accepted through a valid/ready load port and committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between application logic (counters, sensor readouts) and the board's segment/anode pins.

## Interface
- `NDIGITS`, 4: number of digits scanned (1..8).
- `PRESCALE`, 12000: clock cycles per digit slot; must be greater than `BLANK`.
- `BLANK`, 16: cycles at the start of each slot with all anodes off; 0 disables blanking.

Ports:
- `clk`  in  1  system clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `value_in`  in  4*NDIGITS  hex nibbles; nibble i drives digit i; digit 0 is least significant.
- `dp_in`  in  NDIGITS  decimal point request per digit, active-high.
- `lz_blank`  in  1  leading-zero blanking enable; sampled live, not latched.
- `load_valid`  in  1  offer `value_in`/`dp_in` for display.
- `load_ready`  out  1  pending buffer empty; capture occurs when valid && ready.
- `seg`  out  7  segments gfedcba, active-low (decoder output).
- `dp`  out  1  decimal point, active-low.
- `an`  out  NDIGITS  digit anodes, active-low; at most one low.
- `frame_done`  out  1  one-cycle pulse in the last cycle of the last slot.

## Operation
- Registers: `disp` (display value plus dp bits), `pend` (pending value), `pend_full`, slot counter `cnt` (0..PRESCALE-1), digit index `idx` (0..NDIGITS-1).
- Per-slot FSM: `BLANK` (cnt < BLANK) -> `SHOW` (cnt >= BLANK). At cnt == PRESCALE-1 the FSM goes to `BLANK` with cnt = 0 and idx = idx+1, wrapping from NDIGITS-1 to 0. If BLANK == 0, the FSM is always in `SHOW`.
- `BLANK`: `an` all 1, `seg` = 7'h7F, `dp` = 1.
- `SHOW`: `an[idx]` = 0; `seg` = decode(disp nibble idx); `dp` = ~disp_dp[idx].
- Leading-zero blanking: when `lz_blank` = 1, digit i (i ≥ 1) is suppressed if nibbles i..NDIGITS-1 are all 0. A suppressed digit is treated as `BLANK` for its whole slot. Digit 0 is never suppressed.
- Load: `load_ready` = ~pend_full. On a handshake, `pend` ← inputs and pend_full ← 1.
- Commit: in the cycle where idx == NDIGITS-1 and cnt == PRESCALE-1, if pend_full then disp ← pend and pend_full ← 0. `frame_done` pulses in this same cycle whether or not a commit happens. No handshake can occur in the commit cycle, because `load_ready` is 0 whenever a commit is pending.
- If `pend_full` is 0 at frame end, `disp` is unchanged and the display keeps repeating.
- `load_valid` with `load_ready` = 0: nothing is captured. The source must hold the data.

## Timing
- `an`, `seg`, `dp` and `frame_done` are registered: one cycle of latency after the internal cnt/idx state.
- Cycle 0 is the first rising edge after `resetn` is released. Slot k occupies internal cycles k*PRESCALE .. k*PRESCALE+PRESCALE-1.
- Digit i is visible on the pins from cycle i*PRESCALE+BLANK+1 through (i+1)*PRESCALE, inclusive.
- Frame period is NDIGITS*PRESCALE cycles.
- A value accepted during frame F is first visible in the first `SHOW` of frame F+1. `load_ready` returns to 1 in the cycle after the commit.
- Reset values: `an` all 1, `seg` 7'h7F, `dp` 1, `load_ready` 1, `frame_done` 0. Internal state: disp = 0, dp bits 0, pend_full = 0, cnt = 0, idx = 0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously) and any pending value is discarded. After release, scanning restarts at digit 0 in `BLANK`.
- `lz_blank` changes take effect from the next registered output cycle.

## Test plan
All scenarios use NDIGITS=4, PRESCALE=8, BLANK=2.
- Reset: hold `resetn` low, toggle all inputs -> `an`=4'b1111, `seg`=7'h7F, `dp`=1, `load_ready`=1, `frame_done`=0. After release, digit 0 shows 0 (`seg`=7'b1000000) during cycles 3..8.
- Load 16'h1234 with lz_blank=0 -> `frame_done` at cycle 31. The next frame shows:
  - `an`=1110, `seg`=0011001 (4);
  - `an`=1101, `seg`=0110000 (3);
  - `an`=1011, `seg`=0100100 (2);
  - `an`=0111, `seg`=1111001 (1).
  - Each digit is on for 6 cycles after 2 blank cycles.
- Leading-zero blanking with lz_blank=1:
  - Value 16'h0050 -> `an` stays 1111 during slots 3 and 2; slot 1 shows 0010010 (5); slot 0 shows 1000000 (0).
  - Value 16'h0000 -> only digit 0 lights.
- Back-to-back loads:
  - Load A accepted -> `load_ready` drops to 0.
  - Load B is held with `load_valid` high and not captured until the commit cycle.
  - `load_ready` returns to 1 the cycle after `frame_done`; B is captured then and shown one frame after A.
- dp_in=4'b0100 with value 16'h8888 -> `dp`=0 only during digit 2's `SHOW` window; `dp`=1 during all blank windows.
- Reset mid-frame: assert `resetn` during slot 2 with pend_full=1 -> outputs return to reset values asynchronously; after release `load_ready`=1, disp=0, and scanning resumes at digit 0.
